// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared constants and types for the L1 data-cache line-refill engine.
// Address split is {tag, index, offset}; one line is four 32-bit words.
package dcache_refill_ctrl_pkg;

  localparam int IDX_W      = 5;
  localparam int TAG_W      = 23;
  localparam int OFF_W      = 4;
  localparam int LINE_WORDS = 4;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_FIN  = 2'd3
  } refill_state_e;

  // Active-low byte enables: the four bytes of word k are cleared.
  function automatic logic [15:0] word_web(input logic [1:0] k);
    word_web = ~(16'h000F << {k, 2'b00});
  endfunction

endpackage

// File: rtl/refill_wr_stage.sv
// Registered write stage: turns one accepted read beat into a single-cycle
// write on the data-array port, one cycle after the beat was accepted.
module refill_wr_stage
  import dcache_refill_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [31:0]      beat,
  input  logic [1:0]       cnt,
  input  logic [IDX_W-1:0] idx,
  input  logic             way,
  output logic             da_cs,
  output logic [15:0]      da_web,
  output logic [IDX_W-1:0] da_a,
  output logic [31:0]      da_di,
  output logic             da_active_way,
  output logic [1:0]       da_active_block
);

  // Address/data hold their last value between writes; only cs/web idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      da_cs           <= 1'b0;
      da_web          <= 16'hFFFF;
      da_a            <= '0;
      da_di           <= '0;
      da_active_way   <= 1'b0;
      da_active_block <= 2'd0;
    end else if (wr_en) begin
      da_cs           <= 1'b1;
      da_web          <= word_web(cnt);
      da_a            <= idx;
      da_di           <= beat;
      da_active_way   <= way;
      da_active_block <= cnt;
    end else begin
      da_cs  <= 1'b0;
      da_web <= 16'hFFFF;
    end
  end

endmodule

// File: rtl/dcache_refill_ctrl.sv
// L1 D-cache line refill: one 4-beat AXI4 INCR read burst per miss, each beat
// written to the data array a cycle later, then the tag entry and a done pulse.
module dcache_refill_ctrl
  import dcache_refill_ctrl_pkg::*;
#(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_WORDS = dcache_refill_ctrl_pkg::LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_way,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic        da_cs,
  output logic [15:0] da_web,
  output logic [4:0]  da_a,
  output logic [31:0] da_di,
  output logic        da_active_way,
  output logic [1:0]  da_active_block,
  output logic        tag_we,
  output logic [4:0]  tag_a,
  output logic        tag_way,
  output logic [23:0] tag_di,
  output logic        done,
  output logic        done_err,
  output logic [1:0]  dbg_state
);

  if (LINE_WORDS != 4) begin : g_bad_line_words
    $error("dcache_refill_ctrl: LINE_WORDS must be 4");
  end

  localparam logic [1:0] LAST_BEAT = 2'(LINE_WORDS - 1);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; the sender holds its payload stable until that edge.
  refill_state_e      state;
  logic [1:0]         cnt;
  logic               err;
  logic [TAG_W-1:0]   lat_tag;
  logic [IDX_W-1:0]   lat_idx;
  logic               lat_way;
  logic               beat_hs;
  logic               err_next;
  logic               unused_off;

  assign unused_off = ^req_addr[OFF_W-1:0];
  assign dbg_state  = state;
  assign beat_hs    = (state == ST_R) && RVALID && RREADY;

  // RLAST must coincide exactly with the fourth beat.
  assign err_next = err || (RRESP != RESP_OKAY) || (RID != AXI_ID) ||
                    (RLAST != (cnt == LAST_BEAT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      ARID      <= '0;
      ARADDR    <= '0;
      ARLEN     <= '0;
      ARSIZE    <= '0;
      ARBURST   <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      cnt       <= 2'd0;
      err       <= 1'b0;
      lat_tag   <= '0;
      lat_idx   <= '0;
      lat_way   <= 1'b0;
      tag_we    <= 1'b0;
      tag_a     <= '0;
      tag_way   <= 1'b0;
      tag_di    <= '0;
      done      <= 1'b0;
      done_err  <= 1'b0;
    end else begin
      done     <= 1'b0;
      done_err <= 1'b0;
      tag_we   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_tag   <= req_addr[31:OFF_W+IDX_W];
            lat_idx   <= req_addr[OFF_W+IDX_W-1:OFF_W];
            lat_way   <= req_way;
            ARADDR    <= {req_addr[31:OFF_W], {OFF_W{1'b0}}};
            ARID      <= AXI_ID;
            ARLEN     <= 4'(LINE_WORDS - 1);
            ARSIZE    <= SIZE_4B;
            ARBURST   <= BURST_INCR;
            ARVALID   <= 1'b1;
            req_ready <= 1'b0;
            cnt       <= 2'd0;
            err       <= 1'b0;
            state     <= ST_AR;
          end
        end
        ST_AR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= ST_R;
          end
        end
        ST_R: begin
          if (beat_hs) begin
            err <= err_next;
            if (RLAST || (cnt == LAST_BEAT)) begin
              RREADY <= 1'b0;
              state  <= ST_FIN;
              // A failed refill leaves the tag entry untouched, so the line stays invalid.
              if (!err_next) begin
                tag_we  <= 1'b1;
                tag_a   <= lat_idx;
                tag_way <= lat_way;
                tag_di  <= {1'b1, lat_tag};
              end
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        ST_FIN: begin
          done      <= 1'b1;
          done_err  <= err;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  refill_wr_stage u_wr_stage (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (beat_hs),
    .beat            (RDATA),
    .cnt             (cnt),
    .idx             (lat_idx),
    .way             (lat_way),
    .da_cs           (da_cs),
    .da_web          (da_web),
    .da_a            (da_a),
    .da_di           (da_di),
    .da_active_way   (da_active_way),
    .da_active_block (da_active_block)
  );

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Bench for dcache_refill_ctrl: per-cycle vector table for the zero-wait,
// SLVERR and early-RLAST bursts, then directed stall/reset/busy sequences.
module tb_dcache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_way;
  logic [31:0] req_addr;
  logic [3:0]  arid, arlen, rid;
  logic [31:0] araddr, rdata;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        da_cs, da_active_way, tag_we, tag_way, done, done_err;
  logic [15:0] da_web;
  logic [4:0]  da_a, tag_a;
  logic [31:0] da_di;
  logic [1:0]  da_active_block, dbg_state;
  logic [23:0] tag_di;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] web_tab [4];

  always #5 clk = ~clk;

  dcache_refill_ctrl #(.AXI_ID(4'd0), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_way(req_way),
    .ARID(arid), .ARADDR(araddr), .ARLEN(arlen), .ARSIZE(arsize), .ARBURST(arburst),
    .ARVALID(arvalid), .ARREADY(arready),
    .RID(rid), .RDATA(rdata), .RRESP(rresp), .RLAST(rlast), .RVALID(rvalid), .RREADY(rready),
    .da_cs(da_cs), .da_web(da_web), .da_a(da_a), .da_di(da_di),
    .da_active_way(da_active_way), .da_active_block(da_active_block),
    .tag_we(tag_we), .tag_a(tag_a), .tag_way(tag_way), .tag_di(tag_di),
    .done(done), .done_err(done_err), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_way;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
  } in_t;

  typedef struct packed {
    logic        req_ready;
    logic        arvalid;
    logic        rready;
    logic        da_cs;
    logic [15:0] da_web;
    logic [31:0] da_di;
    logic [4:0]  da_a;
    logic        da_way;
    logic [31:0] araddr;
    logic        tag_we;
    logic [23:0] tag_di;
    logic        done;
    logic        done_err;
  } exp_t;

  typedef struct packed {
    exp_t e;
    in_t  i;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic in_t i_idle();
    i_idle = '0;
  endfunction

  function automatic in_t i_req(input logic [31:0] a, input logic w);
    i_req = '0;
    i_req.req_valid = 1'b1;
    i_req.req_addr  = a;
    i_req.req_way   = w;
  endfunction

  function automatic in_t i_ar();
    i_ar = '0;
    i_ar.arready = 1'b1;
  endfunction

  function automatic in_t i_beat(input logic [31:0] d, input logic [1:0] r, input logic l);
    i_beat = '0;
    i_beat.rvalid = 1'b1;
    i_beat.rdata  = d;
    i_beat.rresp  = r;
    i_beat.rlast  = l;
  endfunction

  function automatic exp_t ex(input logic rdy, input logic arv, input logic rrdy, input logic cs,
                              input logic [15:0] web, input logic [31:0] di, input logic [4:0] a,
                              input logic w, input logic [31:0] ara, input logic twe,
                              input logic [23:0] tdi, input logic dn, input logic de);
    ex = '{rdy, arv, rrdy, cs, web, di, a, w, ara, twe, tdi, dn, de};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t v);
    req_valid = v.req_valid;
    req_addr  = v.req_addr;
    req_way   = v.req_way;
    arready   = v.arready;
    rvalid    = v.rvalid;
    rdata     = v.rdata;
    rresp     = v.rresp;
    rlast     = v.rlast;
    rid       = 4'd0;
  endtask

  task automatic check_vec(input int n, input exp_t e);
    chk($sformatf("v%0d.req_ready", n), 32'(req_ready), 32'(e.req_ready));
    chk($sformatf("v%0d.arvalid", n),   32'(arvalid),   32'(e.arvalid));
    chk($sformatf("v%0d.rready", n),    32'(rready),    32'(e.rready));
    chk($sformatf("v%0d.da_cs", n),     32'(da_cs),     32'(e.da_cs));
    chk($sformatf("v%0d.da_web", n),    32'(da_web),    32'(e.da_web));
    chk($sformatf("v%0d.da_di", n),     da_di,          e.da_di);
    chk($sformatf("v%0d.da_a", n),      32'(da_a),      32'(e.da_a));
    chk($sformatf("v%0d.da_way", n),    32'(da_active_way), 32'(e.da_way));
    chk($sformatf("v%0d.araddr", n),    araddr,         e.araddr);
    chk($sformatf("v%0d.tag_we", n),    32'(tag_we),    32'(e.tag_we));
    chk($sformatf("v%0d.tag_di", n),    32'(tag_di),    32'(e.tag_di));
    chk($sformatf("v%0d.done", n),      32'(done),      32'(e.done));
    chk($sformatf("v%0d.done_err", n),  32'(done_err),  32'(e.done_err));
  endtask

  // Present a request and confirm it is taken into AR on the next edge.
  task automatic req_phase(input logic [31:0] a, input logic w, input logic hold);
    req_valid = 1'b1;
    req_addr  = a;
    req_way   = w;
    @(negedge clk);
    chk("req.arvalid", 32'(arvalid), 32'd1);
    chk("req.araddr", araddr, {a[31:4], 4'h0});
    chk("req.req_ready", 32'(req_ready), 32'd0);
    if (!hold) req_valid = 1'b0;
  endtask

  // Zero-wait AR handshake and four clean beats, checking each write and done.
  task automatic burst_phase(input logic [4:0] idx, input logic w, input logic [22:0] tag,
                             input logic [31:0] base);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("bst.rready", 32'(rready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1;
      rdata  = base + 32'(k);
      rlast  = (k == 3);
      @(negedge clk);
      chk($sformatf("bst.cs%0d", k), 32'(da_cs), 32'd1);
      chk($sformatf("bst.web%0d", k), 32'(da_web), 32'(web_tab[k]));
      chk($sformatf("bst.di%0d", k), da_di, base + 32'(k));
      chk($sformatf("bst.a%0d", k), 32'(da_a), 32'(idx));
      chk($sformatf("bst.way%0d", k), 32'(da_active_way), 32'(w));
      chk($sformatf("bst.blk%0d", k), 32'(da_active_block), k);
      chk($sformatf("bst.busy%0d", k), 32'(req_ready), 32'd0);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk("bst.tag_we", 32'(tag_we), 32'd1);
    chk("bst.tag_a", 32'(tag_a), 32'(idx));
    chk("bst.tag_way", 32'(tag_way), 32'(w));
    chk("bst.tag_di", 32'(tag_di), 32'({1'b1, tag}));
    @(negedge clk);
    chk("bst.done", 32'(done), 32'd1);
    chk("bst.done_err", 32'(done_err), 32'd0);
    chk("bst.req_ready", 32'(req_ready), 32'd1);
    chk("bst.tag_we_off", 32'(tag_we), 32'd0);
    chk("bst.cs_off", 32'(da_cs), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    web_tab[0] = 16'hFFF0;
    web_tab[1] = 16'hFF0F;
    web_tab[2] = 16'hF0FF;
    web_tab[3] = 16'h0FFF;

    // Basic refill: 0x1234 -> tag 9, index 3, way 1.
    vecs[0]  = '{ex(1,0,0,0,16'hFFFF,32'h0,5'h0,0,32'h0,0,24'h0,0,0),          i_req(32'h0000_1234, 1'b1)};
    vecs[1]  = '{ex(0,1,0,0,16'hFFFF,32'h0,5'h0,0,32'h1230,0,24'h0,0,0),       i_ar()};
    vecs[2]  = '{ex(0,0,1,0,16'hFFFF,32'h0,5'h0,0,32'h1230,0,24'h0,0,0),       i_beat(32'hA000_0000, 2'b00, 1'b0)};
    vecs[3]  = '{ex(0,0,1,1,16'hFFF0,32'hA000_0000,5'h3,1,32'h1230,0,24'h0,0,0), i_beat(32'hA000_0001, 2'b00, 1'b0)};
    vecs[4]  = '{ex(0,0,1,1,16'hFF0F,32'hA000_0001,5'h3,1,32'h1230,0,24'h0,0,0), i_beat(32'hA000_0002, 2'b00, 1'b0)};
    vecs[5]  = '{ex(0,0,1,1,16'hF0FF,32'hA000_0002,5'h3,1,32'h1230,0,24'h0,0,0), i_beat(32'hA000_0003, 2'b00, 1'b1)};
    vecs[6]  = '{ex(0,0,0,1,16'h0FFF,32'hA000_0003,5'h3,1,32'h1230,1,24'h800009,0,0), i_idle()};
    vecs[7]  = '{ex(1,0,0,0,16'hFFFF,32'hA000_0003,5'h3,1,32'h1230,0,24'h800009,1,0), i_idle()};
    // SLVERR on beat 2: 0xA58 -> tag 5, index 5, way 0.
    vecs[8]  = '{ex(1,0,0,0,16'hFFFF,32'hA000_0003,5'h3,1,32'h1230,0,24'h800009,0,0), i_req(32'h0000_0A58, 1'b0)};
    vecs[9]  = '{ex(0,1,0,0,16'hFFFF,32'hA000_0003,5'h3,1,32'hA50,0,24'h800009,0,0),  i_ar()};
    vecs[10] = '{ex(0,0,1,0,16'hFFFF,32'hA000_0003,5'h3,1,32'hA50,0,24'h800009,0,0),  i_beat(32'hB000_0000, 2'b00, 1'b0)};
    vecs[11] = '{ex(0,0,1,1,16'hFFF0,32'hB000_0000,5'h5,0,32'hA50,0,24'h800009,0,0),  i_beat(32'hB000_0001, 2'b00, 1'b0)};
    vecs[12] = '{ex(0,0,1,1,16'hFF0F,32'hB000_0001,5'h5,0,32'hA50,0,24'h800009,0,0),  i_beat(32'hB000_0002, 2'b10, 1'b0)};
    vecs[13] = '{ex(0,0,1,1,16'hF0FF,32'hB000_0002,5'h5,0,32'hA50,0,24'h800009,0,0),  i_beat(32'hB000_0003, 2'b00, 1'b1)};
    vecs[14] = '{ex(0,0,0,1,16'h0FFF,32'hB000_0003,5'h5,0,32'hA50,0,24'h800009,0,0),  i_idle()};
    vecs[15] = '{ex(1,0,0,0,16'hFFFF,32'hB000_0003,5'h5,0,32'hA50,0,24'h800009,1,1),  i_idle()};
    // Early RLAST on beat 1: 0xFFFFFFFC -> index 0x1F, way 1, ARADDR aligned down.
    vecs[16] = '{ex(1,0,0,0,16'hFFFF,32'hB000_0003,5'h5,0,32'hA50,0,24'h800009,0,0),  i_req(32'hFFFF_FFFC, 1'b1)};
    vecs[17] = '{ex(0,1,0,0,16'hFFFF,32'hB000_0003,5'h5,0,32'hFFFF_FFF0,0,24'h800009,0,0), i_ar()};
    vecs[18] = '{ex(0,0,1,0,16'hFFFF,32'hB000_0003,5'h5,0,32'hFFFF_FFF0,0,24'h800009,0,0), i_beat(32'hC000_0000, 2'b00, 1'b0)};
    vecs[19] = '{ex(0,0,1,1,16'hFFF0,32'hC000_0000,5'h1F,1,32'hFFFF_FFF0,0,24'h800009,0,0), i_beat(32'hC000_0001, 2'b00, 1'b1)};
    vecs[20] = '{ex(0,0,0,1,16'hFF0F,32'hC000_0001,5'h1F,1,32'hFFFF_FFF0,0,24'h800009,0,0), i_idle()};
    vecs[21] = '{ex(1,0,0,0,16'hFFFF,32'hC000_0001,5'h1F,1,32'hFFFF_FFF0,0,24'h800009,1,1), i_idle()};
    vecs[22] = '{ex(1,0,0,0,16'hFFFF,32'hC000_0001,5'h1F,1,32'hFFFF_FFF0,0,24'h800009,0,0), i_idle()};

    // Clock/reset
    rst = 1'b1;
    apply(i_idle());
    @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.arvalid", 32'(arvalid), 32'd0);
    chk("rst.arlen", 32'(arlen), 32'd0);
    chk("rst.da_web", 32'(da_web), 32'hFFFF);
    chk("rst.state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < NV; n++) begin
      @(negedge clk);
      check_vec(n, vecs[n].e);
      apply(vecs[n].i);
    end
    chk("rlast.state_idle", 32'(dbg_state), 32'd0);

    // Stalls: AR held off 3 cycles, an idle cycle after every beat. 0x40 -> index 4, tag 0.
    req_valid = 1'b1;
    req_addr  = 32'h0000_0040;
    req_way   = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("stl.arvalid%0d", s), 32'(arvalid), 32'd1);
      chk($sformatf("stl.araddr%0d", s), araddr, 32'h0000_0040);
      chk($sformatf("stl.arlen%0d", s), 32'(arlen), 32'd3);
      chk($sformatf("stl.arsize%0d", s), 32'(arsize), 32'd2);
      chk($sformatf("stl.arburst%0d", s), 32'(arburst), 32'd1);
      chk($sformatf("stl.arid%0d", s), 32'(arid), 32'd0);
      if (s == 3) arready = 1'b1;
      @(negedge clk);
    end
    arready = 1'b0;
    chk("stl.ar_done", 32'(arvalid), 32'd0);
    chk("stl.rready", 32'(rready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1;
      rdata  = 32'hD000_0000 + 32'(k);
      rlast  = (k == 3);
      @(negedge clk);
      rvalid = 1'b0;
      rlast  = 1'b0;
      chk($sformatf("stl.cs%0d", k), 32'(da_cs), 32'd1);
      chk($sformatf("stl.web%0d", k), 32'(da_web), 32'(web_tab[k]));
      chk($sformatf("stl.di%0d", k), da_di, 32'hD000_0000 + 32'(k));
      chk($sformatf("stl.a%0d", k), 32'(da_a), 32'd4);
      if (k < 3) begin
        @(negedge clk);
        chk($sformatf("stl.gap_cs%0d", k), 32'(da_cs), 32'd0);
        chk($sformatf("stl.gap_web%0d", k), 32'(da_web), 32'hFFFF);
      end
    end
    chk("stl.tag_we", 32'(tag_we), 32'd1);
    chk("stl.tag_a", 32'(tag_a), 32'd4);
    chk("stl.tag_di", 32'(tag_di), 32'h0080_0000);
    @(negedge clk);
    chk("stl.done", 32'(done), 32'd1);
    chk("stl.done_err", 32'(done_err), 32'd0);
    chk("stl.cs_off", 32'(da_cs), 32'd0);

    // Mid-burst reset after beat 1, then a clean refill of 0x554 (index 0x15, tag 2).
    @(negedge clk);
    req_phase(32'h0000_0100, 1'b1, 1'b0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rvalid = 1'b1;
      rdata  = 32'hE000_0000 + 32'(k);
      @(negedge clk);
    end
    rvalid = 1'b0;
    rst    = 1'b1;
    #1;
    chk("mrst.state", 32'(dbg_state), 32'd0);
    chk("mrst.req_ready", 32'(req_ready), 32'd1);
    chk("mrst.arvalid", 32'(arvalid), 32'd0);
    chk("mrst.rready", 32'(rready), 32'd0);
    chk("mrst.da_cs", 32'(da_cs), 32'd0);
    chk("mrst.da_web", 32'(da_web), 32'hFFFF);
    chk("mrst.da_di", da_di, 32'd0);
    chk("mrst.da_a", 32'(da_a), 32'd0);
    chk("mrst.araddr", araddr, 32'd0);
    chk("mrst.tag_di", 32'(tag_di), 32'd0);
    chk("mrst.done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req_phase(32'h0000_0554, 1'b0, 1'b0);
    burst_phase(5'h15, 1'b0, 23'h2, 32'hF000_0000);

    // Busy request: req_valid stays high; the second refill starts only after done.
    @(negedge clk);
    req_phase(32'h0001_0080, 1'b1, 1'b1);
    burst_phase(5'h08, 1'b1, 23'h80, 32'h1000_0000);
    chk("busy.no_ar_at_done", 32'(arvalid), 32'd0);
    req_phase(32'h0001_0080, 1'b1, 1'b0);
    burst_phase(5'h08, 1'b1, 23'h80, 32'h2000_0000);
    @(negedge clk);
    chk("end.state", 32'(dbg_state), 32'd0);
    chk("end.done_clear", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
